mshr_pair_alloc_arb: RTL
========================

# mshr_pair_alloc_arb

Allocation controller for the MSHR entry pool. It tracks which entries are busy, keeps a small buffer of pre-reserved entry-ID pairs, and shares those pairs among several requesters by round-robin arbitration. It accepts entry releases from retiring MSHRs and supports a flush sequence that returns the pool to fully free. It sits between the request pipelines and the MSHR array, replacing per-pipe direct allocation.

## Interface
- ENTRY_NUM, 32, number of MSHR entries (≥4)
- ENTRY_ID_WIDTH, $clog2(ENTRY_NUM), entry index width
- REQ_NUM, 4, number of requesters (≥2)
- PRE_ALLO_DEPTH, 2, pair-buffer depth (≥1)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  REQ_NUM  per-requester allocation request
- req_rdy  out  REQ_NUM  one-hot grant; a pair is handed over when req_vld[i] && req_rdy[i]
- grant_id_1  out  ENTRY_ID_WIDTH  lower entry ID of the granted pair
- grant_id_2  out  ENTRY_ID_WIDTH  higher entry ID of the granted pair
- rel_vld  in  1  entry release strobe
- rel_id  in  ENTRY_ID_WIDTH  entry being released
- flush_req  in  1  single-cycle pulse that starts a flush
- flush_done  out  1  single-cycle pulse when the flush completes
- free_cnt  out  ENTRY_ID_WIDTH+1  number of entries not busy (registered)
- busy_vec  out  ENTRY_NUM  registered busy bitmap
- err  out  1  sticky illegal-release flag

## Operation
- busy[ENTRY_NUM]: an entry is set when it is pushed into the pair buffer and cleared when it is released. Entries in the buffer count as busy.
- Refill: in RUN, if the buffer is not full (registered count) and the registered busy map has ≥2 zeros, push {lowest free, second-lowest free} and set both busy bits. At most one pair is pushed per cycle.
- Grant, in RUN only: if the buffer is non-empty, exactly one req_rdy bit is asserted, for the requester selected among the asserted req_vld bits. grant_id_1/2 show the buffer head. The head pops only on handshake. req_rdy is all zero when no request is pending or the buffer is empty.
- Arbitration: round-robin. The pointer moves to one past the winner only on a handshake. Reset pointer is 0.
- Release: rel_vld clears busy[rel_id] at the next edge.
  - If busy[rel_id] is already 0, or rel_id is held in the pair buffer, err is set and busy is left unchanged.
  - err is cleared only by reset.
- Release and refill in the same cycle are independent. Refill uses the registered busy map, so a released entry becomes eligible one cycle later.
- FSM:
  - RUN: normal operation.
  - FLUSH_DROP: one cycle. Empties the buffer and clears the busy bits of its buffered entries. No grants, no refill.
  - FLUSH_WAIT: no grants, no refill. Releases are still accepted. Stays here until busy_vec == 0.
  - FLUSH_DONE: one cycle. Asserts flush_done, then returns to RUN.
- flush_req is ignored outside RUN. A handshake in the same cycle as flush_req still completes, and its pair is not dropped.

## Timing
- Reset values: busy_vec=0, buffer empty, req_rdy=0, grant_id_1/2=0, flush_done=0, err=0, free_cnt=ENTRY_NUM, FSM=RUN, RR pointer=0.
- Grant path is combinational: req_vld→req_rdy and head→grant_id_* in the same cycle. No registered output on the grant path.
- After reset deassertion:
  - Edge 1 pushes {0,1}; req_rdy can assert in the following cycle.
  - Edge 2 pushes {2,3}; the buffer (depth 2) is then full.
- Pop-to-refill latency is 1 cycle: the slot freed by a pop is refilled at the next edge, because fullness is judged on the registered count.
- Release-to-reuse latency is 2 edges: the busy bit clears at edge 1 and a pair containing the entry can be pushed at edge 2.
- Pool exhausted (<2 free): no push. Grants continue until the buffer is empty, then req_rdy=0.
- Flush takes at least 3 cycles after flush_req: DROP, WAIT (≥1), DONE.
- free_cnt and busy_vec update on the same edge as the busy register.
- Asserting reset mid-flush or mid-operation returns everything to reset values immediately. No flush_done is generated.

## Configuration
- PAIR_ALLOC_RR_EN defined: round-robin arbitration as above.
- PAIR_ALLOC_RR_EN undefined: fixed priority (lowest asserted req_vld index wins). The pointer register is not instantiated. All other behaviour is identical.

## Test plan
- Reset, then idle 3 cycles → buffer head {0,1}, second entry {2,3}, free_cnt=28, req_rdy=0.
- req_vld=4'b1111 held for 4 cycles (RR_EN) → grants to requesters 0,1,2,3 in order; pairs {0,1},{2,3},{4,5},{6,7}; free_cnt reaches 20.
- Grant all 16 pairs without releases → the 17th request sees req_rdy=0. Then rel_id=5 and rel_id=9 → a new pair {5,9} is pushed 2 edges after the second release and is granted.
- rel_vld with rel_id=20 while entry 20 is free → err=1, busy_vec unchanged, err persists until reset.
- With 6 entries granted and 2 pairs buffered, pulse flush_req, then release the 6 entries over 10 cycles → no grants during the flush; busy_vec=0 after the last release; flush_done pulses once; then refill restarts at {0,1}.
- Undefined PAIR_ALLOC_RR_EN, req_vld=4'b0110 held → requester 1 wins every cycle; requester 2 is never granted while requester 1 is asserted.

Source files
------------

// File: rtl/mshr_pair_alloc_arb_if.sv
// ---------------------------------------------------------------------------
// mshr_pair_alloc_arb_if
//   Bundle of signals between the request pipelines / MSHR array (master)
//   and the pair allocation controller (slave).
//
//   req_vld    [REQ_NUM]          requester -> alloc : allocation request
//   req_rdy    [REQ_NUM]          alloc -> requester : one-hot grant
//   grant_id_1 [ENTRY_ID_WIDTH]   alloc -> requester : lower ID of head pair
//   grant_id_2 [ENTRY_ID_WIDTH]   alloc -> requester : higher ID of head pair
//   rel_vld / rel_id              MSHR -> alloc      : entry release
//   flush_req                     ctrl -> alloc      : start flush (pulse)
//   flush_done                    alloc -> ctrl      : flush finished (pulse)
//   free_cnt   [ENTRY_ID_WIDTH+1] number of non-busy entries (registered)
//   busy_vec   [ENTRY_NUM]        registered busy bitmap
//   err                           sticky illegal-release flag
//   fsm_state  [2]                debug view of the controller state:
//                                 0 RUN, 1 FLUSH_DROP, 2 FLUSH_WAIT,
//                                 3 FLUSH_DONE
//
// Handshake: requester i receives the head pair on every cycle where
// req_vld[i] && req_rdy[i] is high at the rising clock edge. req_rdy is a
// combinational function of req_vld, so a requester must not make req_vld
// depend on req_rdy. Once asserted, req_vld may be dropped without penalty;
// the arbiter never commits a pair unless both bits are high.
// ---------------------------------------------------------------------------
interface mshr_pair_alloc_arb_if #(
    parameter int ENTRY_NUM      = 32,
    parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
    parameter int REQ_NUM        = 4
);
    logic [REQ_NUM-1:0]        req_vld;
    logic [REQ_NUM-1:0]        req_rdy;
    logic [ENTRY_ID_WIDTH-1:0] grant_id_1;
    logic [ENTRY_ID_WIDTH-1:0] grant_id_2;
    logic                      rel_vld;
    logic [ENTRY_ID_WIDTH-1:0] rel_id;
    logic                      flush_req;
    logic                      flush_done;
    logic [ENTRY_ID_WIDTH:0]   free_cnt;
    logic [ENTRY_NUM-1:0]      busy_vec;
    logic                      err;
    logic [1:0]                fsm_state;

    modport master (
        output req_vld, rel_vld, rel_id, flush_req,
        input  req_rdy, grant_id_1, grant_id_2, flush_done,
               free_cnt, busy_vec, err, fsm_state
    );

    modport slave (
        input  req_vld, rel_vld, rel_id, flush_req,
        output req_rdy, grant_id_1, grant_id_2, flush_done,
               free_cnt, busy_vec, err, fsm_state
    );
endinterface

// File: rtl/mshr_pair_alloc_arb.sv
// ---------------------------------------------------------------------------
// mshr_pair_alloc_arb
//   Allocation controller for the MSHR entry pool. Keeps a busy bitmap, a
//   small FIFO of pre-reserved {lowest free, second-lowest free} entry pairs,
//   and hands the head pair to one requester per cycle. Releases return
//   entries to the pool; a flush drops the buffered pairs and waits until
//   every entry has been released.
//
//   Build option PAIR_ALLOC_RR_EN:
//     defined   -> round-robin arbitration among requesters
//     undefined -> fixed priority, lowest asserted req_vld index wins
//
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset
//     bus    mshr_pair_alloc_arb_if.slave (request/grant, release, flush,
//            status and debug state)
// ---------------------------------------------------------------------------
module mshr_pair_alloc_arb #(
    parameter int ENTRY_NUM      = 32,
    parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
    parameter int REQ_NUM        = 4,
    parameter int PRE_ALLO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mshr_pair_alloc_arb_if.slave bus
);
    localparam int CNT_W = $clog2(PRE_ALLO_DEPTH + 1);
    localparam int RR_W  = $clog2(REQ_NUM);
    localparam int FC_W  = ENTRY_ID_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PRE_ALLO_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FLUSH_DROP = 2'd1,
        ST_FLUSH_WAIT = 2'd2,
        ST_FLUSH_DONE = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [ENTRY_NUM-1:0]      busy_q, busy_d;
    logic [FC_W-1:0]           free_cnt_q, free_cnt_d;
    logic                      err_q;
    logic [ENTRY_ID_WIDTH-1:0] buf_lo_q [PRE_ALLO_DEPTH];
    logic [ENTRY_ID_WIDTH-1:0] buf_hi_q [PRE_ALLO_DEPTH];
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          wr_idx;

    logic [ENTRY_ID_WIDTH-1:0] free_lo, free_hi;
    logic                      found_lo, found_hi;
    logic                      push, pop;
    logic                      win_vld;
    logic [RR_W-1:0]           win;
    logic [REQ_NUM-1:0]        rdy;
    logic                      rel_busy, rel_in_buf, rel_ok;
    logic [ENTRY_NUM-1:0]      drop_mask;
    logic                      flush_done;

`ifdef PAIR_ALLOC_RR_EN
    localparam int CW = RR_W + 1;
    logic [RR_W-1:0] rr_q;
    logic [CW-1:0]   cand;
`endif

    // Two lowest zeros of the registered busy map.
    always_comb begin
        free_lo  = '0;
        free_hi  = '0;
        found_lo = 1'b0;
        found_hi = 1'b0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (!busy_q[i]) begin
                if (!found_lo) begin
                    free_lo  = ENTRY_ID_WIDTH'(i);
                    found_lo = 1'b1;
                end else if (!found_hi) begin
                    free_hi  = ENTRY_ID_WIDTH'(i);
                    found_hi = 1'b1;
                end
            end
        end
    end

    // Fullness uses the registered count, so a slot freed by a pop this
    // cycle is refilled one edge later rather than in the same cycle.
    assign push = (state_q == ST_RUN) && (cnt_q < DEPTH_C) && found_hi;

    // Grant arbitration: only while running and a pair is available.
    always_comb begin
        rdy     = '0;
        win     = '0;
        win_vld = 1'b0;
`ifdef PAIR_ALLOC_RR_EN
        cand    = '0;
`endif
        if (state_q == ST_RUN && cnt_q != '0) begin
`ifdef PAIR_ALLOC_RR_EN
            // Scan starting at the pointer, wrapping at REQ_NUM.
            for (int k = 0; k < REQ_NUM; k++) begin
                cand = {1'b0, rr_q} + CW'(k);
                if (cand >= CW'(REQ_NUM)) begin
                    cand = cand - CW'(REQ_NUM);
                end
                if (!win_vld && bus.req_vld[cand[RR_W-1:0]]) begin
                    win_vld = 1'b1;
                    win     = cand[RR_W-1:0];
                end
            end
`else
            for (int k = 0; k < REQ_NUM; k++) begin
                if (!win_vld && bus.req_vld[k]) begin
                    win_vld = 1'b1;
                    win     = RR_W'(k);
                end
            end
`endif
            if (win_vld) begin
                rdy[win] = 1'b1;
            end
        end
    end

    // req_rdy only goes to an asserting requester, so any grant is a handshake.
    assign pop    = win_vld;
    assign wr_idx = pop ? (cnt_q - CNT_W'(1)) : cnt_q;

    // Release legality and the set of entries currently held in the buffer.
    always_comb begin
        rel_busy   = 1'b0;
        rel_in_buf = 1'b0;
        drop_mask  = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (ENTRY_ID_WIDTH'(i) == bus.rel_id) begin
                rel_busy = busy_q[i];
            end
        end
        for (int j = 0; j < PRE_ALLO_DEPTH; j++) begin
            if (CNT_W'(j) < cnt_q) begin
                if (buf_lo_q[j] == bus.rel_id || buf_hi_q[j] == bus.rel_id) begin
                    rel_in_buf = 1'b1;
                end
                for (int i = 0; i < ENTRY_NUM; i++) begin
                    if (ENTRY_ID_WIDTH'(i) == buf_lo_q[j] ||
                        ENTRY_ID_WIDTH'(i) == buf_hi_q[j]) begin
                        drop_mask[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign rel_ok = bus.rel_vld && rel_busy && !rel_in_buf;

    // Next busy map: refill sets, release and flush-drop clear. The three
    // sources never touch the same entry, so their order does not matter.
    always_comb begin
        busy_d     = busy_q;
        free_cnt_d = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (push && (ENTRY_ID_WIDTH'(i) == free_lo ||
                         ENTRY_ID_WIDTH'(i) == free_hi)) begin
                busy_d[i] = 1'b1;
            end
            if (rel_ok && ENTRY_ID_WIDTH'(i) == bus.rel_id) begin
                busy_d[i] = 1'b0;
            end
            if (state_q == ST_FLUSH_DROP && drop_mask[i]) begin
                busy_d[i] = 1'b0;
            end
        end
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (!busy_d[i]) begin
                free_cnt_d = free_cnt_d + FC_W'(1);
            end
        end
    end

    // Flush sequencing.
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.flush_req) begin
                    state_d = ST_FLUSH_DROP;
                end
            end
            ST_FLUSH_DROP: begin
                state_d = ST_FLUSH_WAIT;
            end
            ST_FLUSH_WAIT: begin
                if (busy_q == '0) begin
                    state_d = ST_FLUSH_DONE;
                end
            end
            ST_FLUSH_DONE: begin
                flush_done = 1'b1;
                state_d    = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            busy_q     <= '0;
            free_cnt_q <= FC_W'(ENTRY_NUM);
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            free_cnt_q <= free_cnt_d;
            if (bus.rel_vld && !rel_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    // Pair FIFO, head at index 0. On a simultaneous pop and push the new
    // pair lands one slot lower, overriding the shifted value there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int j = 0; j < PRE_ALLO_DEPTH; j++) begin
                buf_lo_q[j] <= '0;
                buf_hi_q[j] <= '0;
            end
        end else if (state_q == ST_FLUSH_DROP) begin
            cnt_q <= '0;
        end else begin
            if (pop) begin
                for (int j = 0; j < PRE_ALLO_DEPTH - 1; j++) begin
                    buf_lo_q[j] <= buf_lo_q[j+1];
                    buf_hi_q[j] <= buf_hi_q[j+1];
                end
            end
            if (push) begin
                for (int j = 0; j < PRE_ALLO_DEPTH; j++) begin
                    if (CNT_W'(j) == wr_idx) begin
                        buf_lo_q[j] <= free_lo;
                        buf_hi_q[j] <= free_hi;
                    end
                end
            end
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef PAIR_ALLOC_RR_EN
    // Pointer moves to one past the winner only when a pair is handed over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else if (pop) begin
            rr_q <= (win == RR_W'(REQ_NUM - 1)) ? '0 : (win + RR_W'(1));
        end
    end
`endif

    assign bus.req_rdy    = rdy;
    assign bus.grant_id_1 = (cnt_q != '0) ? buf_lo_q[0] : '0;
    assign bus.grant_id_2 = (cnt_q != '0) ? buf_hi_q[0] : '0;
    assign bus.flush_done = flush_done;
    assign bus.free_cnt   = free_cnt_q;
    assign bus.busy_vec   = busy_q;
    assign bus.err        = err_q;
    assign bus.fsm_state  = state_q;

endmodule
